// File: rtl/addsub_serial_ctrl.sv
// -----------------------------------------------------------------------------
// addsub_serial_ctrl
//   Sequencer for multi-word add/subtract built on a single 4-bit add/sub
//   nibble slice. A request captures two WIDTH-bit operands and a subtract
//   select. The slice is then stepped once per nibble, least significant
//   nibble first, with the carry held in a register between steps. The result
//   and flags are returned over a valid/ready handshake.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising edge where valid && ready are both high.
//   start_ready is high only in IDLE, so a start_valid seen in RUN or DONE is
//   dropped rather than queued. done_valid is high only in DONE, so done_ready
//   has no effect in IDLE or RUN. The result and flags stay stable for as long
//   as done_valid is held.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start_valid/ready  request handshake; a, b, sub are sampled on accept
//   a, b               WIDTH-bit operands
//   sub                0: a+b, 1: a-b (two's complement)
//   busy               high while nibble steps are running
//   done_valid/ready   result handshake
//   result             WIDTH-bit sum or difference
//   cout               final carry; for subtract, 1 means no borrow (a >= b)
//   ovf                signed two's-complement overflow
// -----------------------------------------------------------------------------
module addsub_serial_ctrl #(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = 4 * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_r, b_r;
    logic             sub_r;
    logic             carry;
    logic [IDXW-1:0]  idx;

    // Nibble slice: operands of the current step and the 5-bit slice output.
    int          nib_base;
    logic [3:0]  a_nib, b_nib;
    logic [4:0]  step_sum;
    logic        last_step;

    always_comb begin
        nib_base  = 4 * int'(idx);
        a_nib     = a_r[nib_base +: 4];
        b_nib     = b_r[nib_base +: 4] ^ {4{sub_r}};
        step_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
        last_step = (idx == LAST_IDX);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        busy        = 1'b0;
        done_valid  = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture and nibble datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            sub_r  <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_r    <= a;
                        b_r    <= b;
                        sub_r  <= sub;
                        // Subtract is a + ~b + 1: the +1 enters as carry-in.
                        carry  <= sub;
                        idx    <= '0;
                        result <= '0;
                    end
                end
                RUN: begin
                    result[nib_base +: 4] <= step_sum[3:0];
                    carry                 <= step_sum[4];
                    if (last_step) begin
                        // On the top nibble, a_nib[3] and b_nib[3] are the
                        // operand sign bits (b already inverted for subtract).
                        cout <= step_sum[4];
                        ovf  <= (a_nib[3] == b_nib[3]) && (step_sum[3] != a_nib[3]);
                    end else begin
                        // idx stops at the last nibble instead of wrapping.
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_addsub_serial_ctrl
//   Randomized and directed bench for addsub_serial_ctrl. A cycle-level
//   reference model tracks the handshake phase and a queue of expected
//   {cout, ovf, result} words computed with plain integer arithmetic. One
//   compare process checks the DUT against the model on every falling edge.
// -----------------------------------------------------------------------------
module tb_addsub_serial_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start_valid = 1'b0;
    logic         sub         = 1'b0;
    logic         done_ready  = 1'b0;
    logic [W-1:0] a           = '0;
    logic [W-1:0] b           = '0;
    logic         start_ready, busy, done_valid, cout, ovf;
    logic [W-1:0] result;

    addsub_serial_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .sub         (sub),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .result      (result),
        .cout        (cout),
        .ovf         (ovf)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Packed expectation: {cout, ovf, result}
    logic [W+1:0] exp_q[$];

    function automatic logic [W+1:0] model_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
        longint sx, sy, sr, smax, smin;
        logic [W:0] u;
        logic c, o;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        if (s) begin
            sr = sx - sy;
            u  = {1'b0, x} - {1'b0, y};
            c  = (x >= y);
        end else begin
            sr = sx + sy;
            u  = {1'b0, x} + {1'b0, y};
            c  = u[W];
        end
        o = (sr > smax) || (sr < smin);
        return {c, o, u[W-1:0]};
    endfunction

    bit m_idle     = 1'b1;
    int m_run_left = 0;
    bit m_done     = 1'b0;
    bit m_zero     = 1'b1;   // outputs still at reset values
    int ops_done   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_idle     = 1'b1;
            m_run_left = 0;
            m_done     = 1'b0;
            m_zero     = 1'b1;
            exp_q.delete();
        end else if (m_idle) begin
            if (start_valid) begin
                exp_q.push_back(model_op(a, b, sub));
                m_idle     = 1'b0;
                m_run_left = NIBBLES;
                m_zero     = 1'b0;
            end
        end else if (m_run_left > 0) begin
            m_run_left--;
            if (m_run_left == 0) m_done = 1'b1;
        end else if (m_done && done_ready) begin
            void'(exp_q.pop_front());
            m_done = 1'b0;
            m_idle = 1'b1;
            ops_done++;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("start_ready", 32'(start_ready), 32'(m_idle));
            chk("busy",        32'(busy),        32'(m_run_left > 0));
            chk("done_valid",  32'(done_valid),  32'(m_done));
            if (m_done && exp_q.size() > 0) begin
                chk("result", 32'(result), 32'(exp_q[0][W-1:0]));
                chk("cout",   32'(cout),   32'(exp_q[0][W+1]));
                chk("ovf",    32'(ovf),    32'(exp_q[0][W]));
            end
            if (m_idle && m_zero) begin
                chk("reset_result", 32'(result), 32'd0);
                chk("reset_cout",   32'(cout),   32'd0);
                chk("reset_ovf",    32'(ovf),    32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int n = 0;
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) begin
            checks++;
            failures++;
            $display("FAIL wait_ready timeout actual=0 required=1 t=%0t", $time);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!done_valid) begin
            checks++;
            failures++;
            $display("FAIL wait_done timeout actual=0 required=1 t=%0t", $time);
        end
    endtask

    // One full operation; optional literal expectation checked at DONE.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          input int hold, input bit use_lit, input logic [W+1:0] lit);
        wait_ready();
        a           = x;
        b           = y;
        sub         = s;
        start_valid = 1'b1;
        @(negedge clk);
        // Scramble inputs and poke ignored handshakes while running.
        start_valid = 1'($urandom_range(0, 1));
        a           = W'($urandom);
        b           = W'($urandom);
        sub         = 1'($urandom_range(0, 1));
        done_ready  = 1'($urandom_range(0, 1));
        wait_done();
        done_ready = 1'b0;
        if (use_lit) begin
            chk("lit_result", 32'(result), 32'(lit[W-1:0]));
            chk("lit_cout",   32'(cout),   32'(lit[W+1]));
            chk("lit_ovf",    32'(ovf),    32'(lit[W]));
        end
        repeat (hold) @(negedge clk);
        start_valid = 1'b0;
        done_ready  = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    logic [W-1:0] edge_vals[6];

    initial begin
        edge_vals[0] = 16'h0000;
        edge_vals[1] = 16'hFFFF;
        edge_vals[2] = 16'h7FFF;
        edge_vals[3] = 16'h8000;
        edge_vals[4] = 16'h0001;
        edge_vals[5] = 16'h00FF;

        // Pin the model to hand-computed values.
        chk("model_add",     32'(model_op(16'h1234, 16'h0FFF, 1'b0)), 32'({2'b00, 16'h2233}));
        chk("model_sub_neg", 32'(model_op(16'h0005, 16'h0007, 1'b1)), 32'({2'b00, 16'hFFFE}));
        chk("model_sub_ovf", 32'(model_op(16'h8000, 16'h0001, 1'b1)), 32'({2'b11, 16'h7FFF}));
        chk("model_add_ovf", 32'(model_op(16'h7FFF, 16'h0001, 1'b0)), 32'({2'b01, 16'h8000}));
        chk("model_add_cy",  32'(model_op(16'hFFFF, 16'h0001, 1'b0)), 32'({2'b10, 16'h0000}));

        // Reset held two cycles, then checked while still asserted.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed operations with literal results.
        run_op(16'h1234, 16'h0FFF, 1'b0, 0, 1'b1, {2'b00, 16'h2233});
        run_op(16'h0005, 16'h0007, 1'b1, 1, 1'b1, {2'b00, 16'hFFFE});
        run_op(16'h8000, 16'h0001, 1'b1, 0, 1'b1, {2'b11, 16'h7FFF});
        run_op(16'h7FFF, 16'h0001, 1'b0, 2, 1'b1, {2'b01, 16'h8000});
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b1, {2'b10, 16'h0000});

        // Backpressure: DONE held 10 cycles with a competing request.
        wait_ready();
        a = 16'hABCD; b = 16'h1111; sub = 1'b0; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        wait_done();
        done_ready  = 1'b0;
        start_valid = 1'b1;
        a = 16'h4000; b = 16'h4000; sub = 1'b0;
        repeat (10) @(negedge clk);
        chk("bp_result", 32'(result), 32'(16'hBCDE));
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        chk("bp_idle_ready", 32'(start_ready), 32'd1);
        @(negedge clk);
        start_valid = 1'b0;
        chk("bp_accepted", 32'(busy), 32'd1);
        wait_done();
        chk("bp_new_result", 32'(result), 32'(16'h8000));
        chk("bp_new_ovf",    32'(ovf),    32'd1);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;

        // Reset during the second RUN cycle aborts the operation.
        wait_ready();
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready",  32'(start_ready), 32'd1);
        chk("abort_done",   32'(done_valid),  32'd0);
        chk("abort_result", 32'(result),      32'd0);
        repeat (8) @(negedge clk);

        // Randomized operations, mixing in boundary operands.
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] x, y;
            x = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom);
            y = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(x, y, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, '0);
        end

        repeat (4) @(negedge clk);
        chk("ops_completed", 32'(ops_done), 32'd67);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
